// File: rtl/crossbar_pkg.sv
// Shared definitions for the AXI-Stream-style crossbar.
//   router_state_t : per-input-port router FSM states
//   ERR_CNT_WIDTH  : width of the dropped-packet counter
//   sat_inc8       : saturating increment for 8-bit counters
// The beat struct {data, dest, last} depends on module parameters, so each
// instantiating module declares it from its own localparams.
package crossbar_pkg;

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} router_state_t;

    localparam int unsigned ERR_CNT_WIDTH = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Generic 2-entry FIFO with registered flags.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_data   : entry to write
//   push        : write request (ignored while not_full is low)
//   pop         : read request (ignored while not_empty is low)
//   head_data   : oldest entry
//   not_full    : registered, low for the first cycle after reset
//   not_empty   : registered
module stream_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_full,
    output logic             not_empty
);

    logic [WIDTH-1:0] mem0, mem1, mem0_nxt, mem1_nxt;
    logic [1:0]       count, count_nxt, wr_idx;
    logic             push_ok, pop_ok;

    assign push_ok   = push && not_full;
    assign pop_ok    = pop && not_empty;
    assign head_data = mem0;

    // mem0 is always the head; a pop shifts mem1 down, and the write slot is
    // the first free one after that shift.
    always_comb begin
        count_nxt = count + {1'b0, push_ok} - {1'b0, pop_ok};
        mem0_nxt  = mem0;
        mem1_nxt  = mem1;
        wr_idx    = pop_ok ? count - 2'd1 : count;
        if (pop_ok) begin
            mem0_nxt = mem1;
        end
        if (push_ok) begin
            if (wr_idx == 2'd0) begin
                mem0_nxt = push_data;
            end else begin
                mem1_nxt = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0      <= '0;
            mem1      <= '0;
            count     <= '0;
            not_full  <= 1'b0;
            not_empty <= 1'b0;
        end else begin
            mem0      <= mem0_nxt;
            mem1      <= mem1_nxt;
            count     <= count_nxt;
            not_full  <= (count_nxt != 2'd2);
            not_empty <= (count_nxt != 2'd0);
        end
    end

endmodule

// File: rtl/s_port_router.sv
// Per-input-port packet router.
//   clk, rst_n            : clock, asynchronous active-low reset
//   s_data_i/dest_i/last_i/valid_i, s_ready_o : upstream beat interface
//   m_data_o, m_last_o    : FIFO head, broadcast to all master ports
//   m_valid_o             : one-hot (or zero) request toward master arbiters
//   m_ready_i             : per-master ready, only the selected bit is used
//   err_cnt_o             : saturating count of dropped packets
// Beats are buffered in a 2-entry FIFO; the first beat of a packet selects
// the destination, which stays locked until the last beat. Packets for a
// nonexistent port are drained at one beat per cycle and counted.
module s_port_router
    import crossbar_pkg::*;
#(
    parameter  int unsigned M_DATA_COUNT = 3,
    parameter  int unsigned T_DATA_WIDTH = 8,
    localparam int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [T_DATA_WIDTH-1:0]  s_data_i,
    input  logic [T_DEST_WIDTH-1:0]  s_dest_i,
    input  logic                     s_last_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    output logic [T_DATA_WIDTH-1:0]  m_data_o,
    output logic                     m_last_o,
    output logic [M_DATA_COUNT-1:0]  m_valid_o,
    input  logic [M_DATA_COUNT-1:0]  m_ready_i,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic [T_DEST_WIDTH-1:0] dest;
        logic                    last;
    } beat_t;

    localparam logic [T_DEST_WIDTH:0] DEST_LIM = (T_DEST_WIDTH + 1)'(M_DATA_COUNT);

    beat_t                   in_beat, head;
    logic                    not_empty, pop, hs, dest_ok, sel_en, err_inc;
    logic [T_DEST_WIDTH-1:0] sel, route, route_nxt;
    router_state_t           state, state_nxt;

    assign in_beat = '{data: s_data_i, dest: s_dest_i, last: s_last_i};

    stream_fifo2 #(
        .WIDTH($bits(beat_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_data (in_beat),
        .push      (s_valid_i),
        .pop       (pop),
        .head_data (head),
        .not_full  (s_ready_o),
        .not_empty (not_empty)
    );

    assign m_data_o = head.data;
    assign m_last_o = head.last;
    assign dest_ok  = ({1'b0, head.dest} < DEST_LIM);

    // Port selection is kept apart from the FSM so the handshake (which
    // depends on the selection) does not feed back into its own block.
    always_comb begin
        sel    = (state == ROUTE) ? route : head.dest;
        sel_en = not_empty && ((state == ROUTE) || ((state == IDLE) && dest_ok));
    end

    always_comb begin
        m_valid_o = '0;
        for (int unsigned i = 0; i < M_DATA_COUNT; i++) begin
            if (sel_en && (sel == T_DEST_WIDTH'(i))) begin
                m_valid_o[i] = 1'b1;
            end
        end
    end

    assign hs = |(m_valid_o & m_ready_i);

    always_comb begin
        state_nxt = state;
        route_nxt = route;
        pop       = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (not_empty) begin
                    if (dest_ok) begin
                        if (hs) begin
                            pop = 1'b1;
                            if (!head.last) begin
                                state_nxt = ROUTE;
                                route_nxt = head.dest;
                            end
                        end
                    end else begin
                        pop     = 1'b1;
                        err_inc = 1'b1;
                        if (!head.last) begin
                            state_nxt = DROP;
                        end
                    end
                end
            end
            ROUTE: begin
                if (hs) begin
                    pop = 1'b1;
                    if (head.last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (not_empty) begin
                    pop = 1'b1;
                    if (head.last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            route     <= '0;
            err_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            route <= route_nxt;
            if (err_inc) begin
                err_cnt_o <= sat_inc8(err_cnt_o);
            end
        end
    end

endmodule

// File: tb/tb_s_port_router.sv
module tb_s_port_router;

    localparam int M = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic [1:0] s_dest = '0;
    logic       s_last = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [2:0] m_valid;
    logic [2:0] m_ready;
    logic [7:0] err_cnt;

    logic [2:0] ready_fixed = '0;
    logic [2:0] ready_rand = '0;
    logic       ready_mode = 1'b0;

    assign m_ready = ready_mode ? ready_rand : ready_fixed;

    s_port_router #(
        .M_DATA_COUNT(3),
        .T_DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_dest_i  (s_dest),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ready_rand = 3'($urandom_range(0, 7));
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: packet-level view of what must come out.
    typedef struct {
        int         port;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    bit   in_pkt = 0;
    int   cur_dest = 0;
    int   err_exp = 0;
    int   accepted = 0;
    int   hs_cnt = 0;

    function automatic void model_accept(input logic [7:0] d, input int dest, input logic last);
        exp_t e;
        if (!in_pkt) begin
            cur_dest = dest;
            if (cur_dest >= M) err_exp = (err_exp < 255) ? err_exp + 1 : 255;
        end
        if (cur_dest < M) begin
            e.port = cur_dest;
            e.data = d;
            e.last = last;
            exp_q.push_back(e);
        end
        in_pkt = !last;
        accepted++;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        in_pkt = 0;
        err_exp = 0;
    endfunction

    // Called and returning at posedge+1; the beat is accepted at the edge
    // following a negedge that sees s_ready high.
    task automatic send_beat(input logic [7:0] d, input logic [1:0] dest,
                             input logic last, output int stalls);
        bit done;
        done = 0;
        stalls = 0;
        s_valid = 1'b1;
        s_data = d;
        s_dest = dest;
        s_last = last;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                model_accept(d, int'(dest), last);
                done = 1;
            end else begin
                stalls++;
                if (stalls > 500) begin
                    checks++;
                    failures++;
                    $display("FAIL send_timeout actual=stalled required=accept");
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_drain actual=%0d required=0", name, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_err_cnt"}, int'(err_cnt), err_exp);
    endtask

    // Output monitor / scoreboard.
    bit         prev_wait = 0;
    logic [2:0] prev_valid;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        logic [2:0] hsv;
        int         port;
        exp_t       e;
        if (!rst_n) begin
            prev_wait = 0;
        end else begin
            hsv = m_valid & m_ready;
            if (prev_wait) begin
                check("hold_valid", int'(m_valid), int'(prev_valid));
                check("hold_data", int'(m_data), int'(prev_data));
                check("hold_last", int'(m_last), int'(prev_last));
            end
            if (m_valid != 0) begin
                check("valid_onehot", $countones(m_valid), 1);
                check("valid_expected", int'(exp_q.size() != 0), 1);
            end
            if (hsv != 0 && exp_q.size() != 0) begin
                port = 0;
                for (int i = 0; i < M; i++) if (hsv[i]) port = i;
                e = exp_q.pop_front();
                check("hs_port", port, e.port);
                check("hs_data", int'(m_data), int'(e.data));
                check("hs_last", int'(m_last), int'(e.last));
                hs_cnt++;
            end
            prev_wait  = (m_valid != 0) && (hsv == 0);
            prev_valid = m_valid;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, tot, a0, h0, len, gap;
        logic [1:0] dst;

        // Reset values.
        #1;
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", int'(s_ready), 0);
        @(posedge clk); #1;
        check("ready_after_first_edge", int'(s_ready), 1);

        // Single beat to port 2, 1-cycle latency, popped in one cycle.
        ready_fixed = 3'b100;
        send_beat(8'hA5, 2'd2, 1'b1, st);
        @(negedge clk);
        check("t1_valid", int'(m_valid), 3'b100);
        check("t1_data", int'(m_data), 8'hA5);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_popped", int'(m_valid), 0);
        check("t1_err", int'(err_cnt), 0);
        @(posedge clk); #1;

        // Route locked on first beat; later dest ignored; then back to IDLE.
        ready_fixed = 3'b111;
        send_beat(8'h11, 2'd1, 1'b0, st);
        send_beat(8'h22, 2'd0, 1'b0, st);
        send_beat(8'h33, 2'd0, 1'b1, st);
        send_beat(8'h44, 2'd2, 1'b1, st);
        wait_drain("t2");

        // Backpressure: only 2 beats fit.
        ready_fixed = 3'b000;
        a0 = accepted;
        fork
            begin
                send_beat(8'h01, 2'd0, 1'b0, st);
                send_beat(8'h02, 2'd0, 1'b0, st);
                send_beat(8'h03, 2'd0, 1'b0, st);
                send_beat(8'h04, 2'd0, 1'b1, st);
            end
            begin
                repeat (5) @(negedge clk);
                check("t3_accepted", accepted - a0, 2);
                check("t3_s_ready", int'(s_ready), 0);
                @(posedge clk); #1;
                ready_fixed = 3'b111;
            end
        join
        wait_drain("t3");

        // Drop a packet to port 3, then a normal packet.
        send_beat(8'hD0, 2'd3, 1'b0, st);
        send_beat(8'hD1, 2'd1, 1'b1, st);
        send_beat(8'h77, 2'd0, 1'b1, st);
        wait_drain("t4");
        check("t4_err_one", int'(err_cnt), 1);

        // Full throughput over an 8-beat packet.
        h0 = hs_cnt;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            send_beat(8'(8'h80 + i), 2'd2, (i == 7), st);
            tot += st;
        end
        check("t5_stalls", tot, 0);
        @(negedge clk); #1;
        check("t5_handshakes", hs_cnt - h0, 8);
        @(posedge clk); #1;
        wait_drain("t5");

        // Reset in the middle of a packet.
        ready_fixed = 3'b000;
        send_beat(8'h61, 2'd1, 1'b0, st);
        send_beat(8'h62, 2'd1, 1'b0, st);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_s_ready", int'(s_ready), 0);
        check("t6_m_valid", int'(m_valid), 0);
        check("t6_m_data", int'(m_data), 0);
        check("t6_m_last", int'(m_last), 0);
        check("t6_err", int'(err_cnt), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_fixed = 3'b100;
        send_beat(8'h5A, 2'd2, 1'b1, st);
        @(negedge clk);
        check("t6_valid", int'(m_valid), 3'b100);
        check("t6_data", int'(m_data), 8'h5A);
        @(posedge clk); #1;
        wait_drain("t6");

        // Randomized traffic with random ready.
        ready_mode = 1'b1;
        for (int p = 0; p < 150; p++) begin
            len = $urandom_range(1, 4);
            dst = 2'($urandom_range(0, 3));
            for (int b = 0; b < len; b++) begin
                send_beat(8'($urandom), (b == 0) ? dst : 2'($urandom_range(0, 3)),
                          (b == len - 1), st);
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        wait_drain("rand");

        // Error counter saturation.
        ready_mode = 1'b0;
        ready_fixed = 3'b111;
        for (int p = 0; p < 260; p++) begin
            send_beat(8'(p), 2'd3, 1'b1, st);
        end
        wait_drain("sat");
        check("sat_255", int'(err_cnt), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
